// File: rtl/loader_pkg.sv
// Shared definitions for the loader router.
//   state_e   : router FSM states (idle, bank strobe, downstream forward, error)
//   ERR_CNT_W : width of the saturating illegal-request counter
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_FWD    = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam int ERR_CNT_W = 8;

endpackage : loader_pkg

// File: rtl/loader_strobe_bank.sv
// One local strobe bank: emits a registered one-hot, one-cycle pulse on
// strobe_o[idx_i] for the cycle following an edge where en_i is high.
// Ports:
//   CLK      - rising-edge clock
//   RESET    - synchronous active-high reset, clears the pulse register
//   en_i     - fire this bank at the current edge
//   idx_i    - bit position to pulse (caller guarantees idx_i < STROBE_WIDTH)
//   strobe_o - registered strobe slice for this bank
module loader_strobe_bank
  import loader_pkg::*;
#(
  parameter int STROBE_WIDTH = 64,
  parameter int IDX_W        = 7
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    en_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [STROBE_WIDTH-1:0] strobe_o
);

  logic [STROBE_WIDTH-1:0] strobe_q;
  logic [STROBE_WIDTH-1:0] strobe_d;

  // Decoder over the full index width so an out-of-range index can never
  // alias onto a valid bit.
  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      if (en_i && (32'(idx_i) == 32'(i))) begin
        strobe_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule : loader_strobe_bank

// File: rtl/loader_router.sv
// Loader router: decodes a request address into either a held one-hot
// downstream select (forward), a single-cycle strobe bit in one of the local
// banks, or an error pulse with a saturating error counter.
// Ports:
//   CLK             - rising-edge clock
//   RESET           - synchronous active-high reset (wins over a request)
//   SELECT_LEVEL    - request valid, accepted only while READY=1
//   ADDRESS         - {route code (SEL_W), index (LOW_W)}
//   READY           - high only in IDLE
//   STROBE          - NB_BANKS x STROBE_WIDTH strobe bits, bank b at b*STROBE_WIDTH
//   SELECT_LEVEL_D  - one-hot downstream select, held HOLD_CYCLES cycles
//   ADDRESS_LEVEL_D - index forwarded downstream, holds last forwarded value
//   ADDR_ERR        - one-cycle pulse on an illegal request
//   ERR_COUNT       - saturating count of illegal requests
module loader_router
  import loader_pkg::*;
#(
  parameter int ADDRESS_SIZE = 10,
  parameter int NB_SLAVES    = 4,
  parameter int NB_BANKS     = 3,
  parameter int STROBE_WIDTH = 64,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   SELECT_LEVEL,
  input  logic [ADDRESS_SIZE-1:0]                ADDRESS,
  output logic                                   READY,
  output logic [NB_BANKS*STROBE_WIDTH-1:0]       STROBE,
  output logic [NB_SLAVES-1:0]                   SELECT_LEVEL_D,
  output logic [ADDRESS_SIZE-$clog2(NB_SLAVES+NB_BANKS)-1:0] ADDRESS_LEVEL_D,
  output logic                                   ADDR_ERR,
  output logic [ERR_CNT_W-1:0]                   ERR_COUNT
);

  localparam int SEL_W  = $clog2(NB_SLAVES + NB_BANKS);
  localparam int LOW_W  = ADDRESS_SIZE - SEL_W;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [NB_SLAVES-1:0]   sel_q, sel_d;
  logic [LOW_W-1:0]       addr_q, addr_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   bank_go;

  logic [SEL_W-1:0]       code;
  logic [LOW_W-1:0]       index;
  logic                   accept;
  logic                   is_fwd;
  logic                   is_bank;

  assign code   = ADDRESS[ADDRESS_SIZE-1 -: SEL_W];
  assign index  = ADDRESS[LOW_W-1:0];
  assign READY  = (state_q == ST_IDLE);
  assign accept = SELECT_LEVEL && READY;

  assign is_fwd  = (32'(code) < 32'(NB_SLAVES));
  assign is_bank = !is_fwd
                && (32'(code) < 32'(NB_SLAVES + NB_BANKS))
                && (32'(index) < 32'(STROBE_WIDTH));

  always_comb begin
    state_d = state_q;
    sel_d   = '0;
    addr_d  = addr_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    bank_go = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_fwd) begin
            state_d = ST_FWD;
            sel_d   = NB_SLAVES'(1) << code;
            addr_d  = index;
            hold_d  = HOLD_W'(HOLD_CYCLES);
          end else if (is_bank) begin
            state_d = ST_STROBE;
            bank_go = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + ERR_CNT_W'(1);
            end
          end
        end
      end

      // hold_q counts the remaining visible select cycles including this one.
      ST_FWD: begin
        if (hold_q <= HOLD_W'(1)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
          sel_d   = sel_q;
        end
      end

      ST_STROBE: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic bank_en;
    assign bank_en = bank_go && (32'(code) == 32'(NB_SLAVES + b));

    loader_strobe_bank #(
      .STROBE_WIDTH (STROBE_WIDTH),
      .IDX_W        (LOW_W)
    ) u_bank (
      .CLK      (CLK),
      .RESET    (RESET),
      .en_i     (bank_en),
      .idx_i    (index),
      .strobe_o (STROBE[b*STROBE_WIDTH +: STROBE_WIDTH])
    );
  end

  assign SELECT_LEVEL_D  = sel_q;
  assign ADDRESS_LEVEL_D = addr_q;
  assign ADDR_ERR        = err_q;
  assign ERR_COUNT       = cnt_q;

endmodule : loader_router

// File: tb/tb_loader_router.sv
module tb_loader_router;

  localparam int AW = 10;
  localparam int NS = 4;
  localparam int NB = 3;
  localparam int SW = 64;
  localparam int HC = 2;
  localparam int LW = 7;
  localparam int BW = NB * SW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          SELECT_LEVEL = 1'b0;
  logic [AW-1:0] ADDRESS = '0;
  logic          READY;
  logic [BW-1:0] STROBE;
  logic [NS-1:0] SELECT_LEVEL_D;
  logic [LW-1:0] ADDRESS_LEVEL_D;
  logic          ADDR_ERR;
  logic [7:0]    ERR_COUNT;

  loader_router #(
    .ADDRESS_SIZE (AW),
    .NB_SLAVES    (NS),
    .NB_BANKS     (NB),
    .STROBE_WIDTH (SW),
    .HOLD_CYCLES  (HC)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .SELECT_LEVEL    (SELECT_LEVEL),
    .ADDRESS         (ADDRESS),
    .READY           (READY),
    .STROBE          (STROBE),
    .SELECT_LEVEL_D  (SELECT_LEVEL_D),
    .ADDRESS_LEVEL_D (ADDRESS_LEVEL_D),
    .ADDR_ERR        (ADDR_ERR),
    .ERR_COUNT       (ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NS-1:0] sel;
    logic [LW-1:0] addr;
    logic [BW-1:0] strobe;
    logic          err;
    logic [7:0]    cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // bit_idx < 0 means no strobe bit expected
  task automatic push(input logic [NS-1:0] sel, input logic [LW-1:0] addr,
                      input int bit_idx, input logic err, input logic [7:0] cnt);
    exp_t e;
    e.sel    = sel;
    e.addr   = addr;
    e.strobe = '0;
    if (bit_idx >= 0) e.strobe[bit_idx] = 1'b1;
    e.err    = err;
    e.cnt    = cnt;
    q.push_back(e);
  endtask

  // Monitor: every cycle with visible activity consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if ((SELECT_LEVEL_D != '0) || (STROBE != '0) || ADDR_ERR) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output sel=%b addr=%0d err=%b cnt=%0d strobe=%h",
                   SELECT_LEVEL_D, ADDRESS_LEVEL_D, ADDR_ERR, ERR_COUNT, STROBE);
        end else begin
          e = q.pop_front();
          if (SELECT_LEVEL_D !== e.sel || ADDRESS_LEVEL_D !== e.addr ||
              STROBE !== e.strobe || ADDR_ERR !== e.err || ERR_COUNT !== e.cnt) begin
            errors++;
            $display("FAIL output got sel=%b addr=%0d err=%b cnt=%0d strobe=%h want sel=%b addr=%0d err=%b cnt=%0d strobe=%h",
                     SELECT_LEVEL_D, ADDRESS_LEVEL_D, ADDR_ERR, ERR_COUNT, STROBE,
                     e.sel, e.addr, e.err, e.cnt, e.strobe);
          end
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a);
    int n;
    n = 0;
    @(negedge CLK);
    while (!READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!READY) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 want=1");
    end
    SELECT_LEVEL = 1'b1;
    ADDRESS      = a;
    @(posedge CLK);
    #1;
    SELECT_LEVEL = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", READY, 1);
    chk("rst_sel", SELECT_LEVEL_D, 0);
    chk("rst_strobe", (STROBE != '0), 0);
    chk("rst_err", ADDR_ERR, 0);
    chk("rst_cnt", ERR_COUNT, 0);
    chk("rst_addr", ADDRESS_LEVEL_D, 0);
    RESET = 1'b0;

    // Forward to slave 1, index 5, held two cycles
    push(4'b0010, 7'd5, -1, 1'b0, 8'd0);
    push(4'b0010, 7'd5, -1, 1'b0, 8'd0);
    issue(10'b001_0000101);
    @(negedge CLK); chk("fwd_ready_c1", READY, 0);
    @(negedge CLK); chk("fwd_ready_c2", READY, 0);
    @(negedge CLK); chk("fwd_ready_c3", READY, 1);
    chk("fwd_sel_off", SELECT_LEVEL_D, 0);
    chk("fwd_addr_hold", ADDRESS_LEVEL_D, 5);
    drain("fwd_drain");

    // Bank 1 index 17 -> bit 81
    push(4'b0000, 7'd5, 81, 1'b0, 8'd0);
    issue(10'b101_0010001);
    @(negedge CLK); chk("bank_ready_c1", READY, 0);
    @(negedge CLK); chk("bank_ready_c2", READY, 1);
    drain("bank_drain");

    // Illegal code, then bank code with index too large
    push(4'b0000, 7'd5, -1, 1'b1, 8'd1);
    issue(10'b111_0000000);
    push(4'b0000, 7'd5, -1, 1'b1, 8'd2);
    issue(10'b100_1100100);
    drain("err_drain");
    chk("err_cnt_hold", ERR_COUNT, 2);

    // Forward to slave 3, index 127, with a bank request dropped while busy
    push(4'b1000, 7'd127, -1, 1'b0, 8'd2);
    push(4'b1000, 7'd127, -1, 1'b0, 8'd2);
    issue(10'b011_1111111);
    @(negedge CLK);
    SELECT_LEVEL = 1'b1;
    ADDRESS      = 10'b100_0000011;
    @(negedge CLK);
    SELECT_LEVEL = 1'b0;
    drain("busy_drop_drain");

    // Bank boundaries: bank 2 bit 63, bank 0 bit 0, bank 2 index 64 illegal
    push(4'b0000, 7'd127, 191, 1'b0, 8'd2);
    issue(10'b110_0111111);
    push(4'b0000, 7'd127, 0, 1'b0, 8'd2);
    issue(10'b100_0000000);
    push(4'b0000, 7'd127, -1, 1'b1, 8'd3);
    issue(10'b110_1000000);
    drain("bound_drain");

    // Reset in the first forward cycle truncates the hold
    push(4'b0001, 7'd9, -1, 1'b0, 8'd3);
    issue(10'b000_0001001);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_sel", SELECT_LEVEL_D, 0);
    chk("midrst_addr", ADDRESS_LEVEL_D, 0);
    chk("midrst_cnt", ERR_COUNT, 0);
    chk("midrst_ready", READY, 1);
    RESET = 1'b0;
    drain("midrst_drain");

    // Reset wins over a simultaneous request
    @(negedge CLK);
    RESET        = 1'b1;
    SELECT_LEVEL = 1'b1;
    ADDRESS      = 10'b010_0000001;
    @(negedge CLK);
    RESET        = 1'b0;
    SELECT_LEVEL = 1'b0;
    chk("rstprio_sel", SELECT_LEVEL_D, 0);
    chk("rstprio_ready", READY, 1);
    drain("rstprio_drain");

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      push(4'b0000, 7'd0, -1, 1'b1, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
      issue(10'b111_0000000);
    end
    drain("sat_drain");
    chk("sat_cnt", ERR_COUNT, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_loader_router
